// File: rtl/imem_loader_pkg.sv
// Shared constants, state encodings and frame helpers for the instruction-memory loader.
package loader_pkg;

   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = ADDR_W + 1;
   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_COUNT = 3'd1;
   localparam state_t S_DATA  = 3'd2;
   localparam state_t S_WRITE = 3'd3;
   localparam state_t S_CHECK = 3'd4;
   localparam state_t S_DONE  = 3'd5;
   localparam state_t S_ERROR = 3'd6;

   // A frame may carry between one and DEPTH words.
   function automatic logic count_ok(input logic [BYTE_W-1:0] n);
      return (n != 8'd0) && (n <= 8'(DEPTH));
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs bytes MSB-first into a word and keeps the running XOR of every shifted byte.
module byte_packer
   import loader_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_shift,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [WORD_W-1:0] o_word,
   output logic              o_word_full,
   output logic [BYTE_W-1:0] o_xor_sum
);

   logic [WORD_W-BYTE_W-1:0] r_word;
   logic [1:0]               r_idx;
   logic [BYTE_W-1:0]        r_xor;

   // Shift register, byte index and checksum accumulator.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_word <= 24'd0;
         r_idx  <= 2'd0;
         r_xor  <= 8'd0;
      end else if (i_clear) begin
         r_word <= 24'd0;
         r_idx  <= 2'd0;
         r_xor  <= 8'd0;
      end else if (i_shift) begin
         r_word <= {r_word[WORD_W-2*BYTE_W-1:0], i_byte};
         r_idx  <= r_idx + 2'd1;
         r_xor  <= r_xor ^ i_byte;
      end
   end

   // Only three bytes are stored; the word is complete when the fourth is being shifted in.
   assign o_word      = {r_word, i_byte};
   assign o_word_full = i_shift && (r_idx == 2'd3);
   assign o_xor_sum   = r_xor;

endmodule

// File: rtl/imem_loader.sv
// Write side of the instruction memory: receives a framed byte stream and loads it word by word.
module imem_loader
   import loader_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load_start,
   input  logic              i_in_valid,
   input  logic [BYTE_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [WORD_W-1:0] o_mem_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   output logic [CNT_W-1:0]  o_words_loaded
);

   state_t              r_state;
   logic                r_in_ready;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [WORD_W-1:0]   r_mem_wdata;
   logic                r_busy;
   logic                r_done;
   logic                r_error;
   logic [CNT_W-1:0]    r_words_loaded;
   logic [CNT_W-1:0]    r_count;

   logic                w_hs;
   logic                w_arm;
   logic                w_shift;
   logic [WORD_W-1:0]   w_word;
   logic                w_word_full;
   logic [BYTE_W-1:0]   w_xor_sum;
   logic [CNT_W-1:0]    w_words_next;

   // in_ready is high exactly in COUNT/DATA/CHECK, so it doubles as the accept qualifier.
   assign w_hs         = i_in_valid && r_in_ready;
   assign w_arm        = i_load_start &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
   assign w_shift      = w_hs && (r_state == S_DATA);
   assign w_words_next = r_words_loaded + CNT_W'(1);

   byte_packer u_packer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (w_arm),
      .i_shift     (w_shift),
      .i_byte      (i_in_data),
      .o_word      (w_word),
      .o_word_full (w_word_full),
      .o_xor_sum   (w_xor_sum)
   );

   // Load FSM; every output is a register updated alongside the state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_in_ready     <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= 32'd0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
         r_words_loaded <= '0;
         r_count        <= '0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (w_arm) begin
                  r_state        <= S_COUNT;
                  r_in_ready     <= 1'b1;
                  r_busy         <= 1'b1;
                  r_done         <= 1'b0;
                  r_error        <= 1'b0;
                  r_words_loaded <= '0;
                  r_mem_addr     <= '0;
               end
            end
            S_COUNT: begin
               if (w_hs) begin
                  if (count_ok(i_in_data)) begin
                     r_count <= i_in_data[CNT_W-1:0];
                     r_state <= S_DATA;
                  end else begin
                     r_state    <= S_ERROR;
                     r_error    <= 1'b1;
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            S_DATA: begin
               if (w_word_full) begin
                  r_state     <= S_WRITE;
                  r_in_ready  <= 1'b0;
                  r_mem_we    <= 1'b1;
                  r_mem_wdata <= w_word;
               end
            end
            S_WRITE: begin
               r_words_loaded <= w_words_next;
               r_in_ready     <= 1'b1;
               // The address stays on the last word so it never wraps at full depth.
               if (w_words_next == r_count) begin
                  r_state <= S_CHECK;
               end else begin
                  r_state    <= S_DATA;
                  r_mem_addr <= r_mem_addr + ADDR_W'(1);
               end
            end
            S_CHECK: begin
               if (w_hs) begin
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b0;
                  if (i_in_data == w_xor_sum) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_ERROR;
                     r_error <= 1'b1;
                  end
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready     = r_in_ready;
   assign o_mem_we       = r_mem_we;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_wdata    = r_mem_wdata;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_error        = r_error;
   assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Table-driven frames plus hand-written reset sequences for imem_loader.
module tb_imem_loader;
   import loader_pkg::*;

   typedef struct {
      logic [7:0]  cnt;
      int          nw;
      logic [31:0] w0, w1, w2;
      logic        inc;
      logic [7:0]  sum;
      int          gap;
      int          pulse_at;
      logic        exp_done;
      logic        exp_err;
      logic [5:0]  exp_wl;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        o_in_ready, o_mem_we, o_busy, o_done, o_error;
   logic [4:0]  o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [5:0]  o_words_loaded;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0]  wr_addr[$];
   logic [31:0] wr_data[$];

   always #5 clk = ~clk;

   imem_loader dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_load_start   (load_start),
      .i_in_valid     (in_valid),
      .i_in_data      (in_data),
      .o_in_ready     (o_in_ready),
      .o_mem_we       (o_mem_we),
      .o_mem_addr     (o_mem_addr),
      .o_mem_wdata    (o_mem_wdata),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_error        (o_error),
      .o_words_loaded (o_words_loaded)
   );

   // While a load is running, in_ready drops exactly in the write-strobe cycle.
   always @(negedge clk) begin
      if (!rst && o_busy) begin
         n_checks++;
         if (o_in_ready !== !o_mem_we) begin
            n_fail++;
            $display("FAIL ready_vs_we t=%0t: in_ready=%0b mem_we=%0b, in_ready must be %0b",
                     $time, o_in_ready, o_mem_we, !o_mem_we);
         end
      end
      if (!rst && o_mem_we) begin
         wr_addr.push_back(o_mem_addr);
         wr_data.push_back(o_mem_wdata);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input vec_t v, input int i);
      if (v.inc) return 32'(i + 1);
      case (i)
         0:       return v.w0;
         1:       return v.w1;
         default: return v.w2;
      endcase
   endfunction

   // Starts and ends on a falling edge; the handshake happens on the rising edge in between.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      repeat ($urandom_range(0, gap)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!o_in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!o_in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: in_ready=0 after %0d cycles, required 1", t);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      logic [31:0] w;
      wr_addr.delete();
      wr_data.delete();
      @(negedge clk);
      pulse_start();
      check({tag, " busy_after_start"}, 32'(o_busy), 32'd1);
      check({tag, " ready_after_start"}, 32'(o_in_ready), 32'd1);
      check({tag, " flags_cleared"}, {30'd0, o_done, o_error}, 32'd0);
      check({tag, " words_cleared"}, 32'(o_words_loaded), 32'd0);
      send_byte(v.cnt, v.gap);
      for (int i = 0; i < v.nw; i++) begin
         if (i == v.pulse_at) begin
            pulse_start();
            check({tag, " start_ignored_busy"}, 32'(o_busy), 32'd1);
         end
         w = word_of(v, i);
         for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], v.gap);
      end
      if (v.nw > 0) send_byte(v.sum, v.gap);
      check({tag, " done"}, 32'(o_done), 32'(v.exp_done));
      check({tag, " error"}, 32'(o_error), 32'(v.exp_err));
      check({tag, " busy_end"}, 32'(o_busy), 32'd0);
      check({tag, " ready_end"}, 32'(o_in_ready), 32'd0);
      check({tag, " words_loaded"}, 32'(o_words_loaded), 32'(v.exp_wl));
      check({tag, " write_count"}, 32'(wr_addr.size()), 32'(v.exp_wl));
      for (int i = 0; i < wr_addr.size() && i < int'(v.exp_wl); i++) begin
         check({tag, " write_addr"}, 32'(wr_addr[i]), 32'(i));
         check({tag, " write_data"}, wr_data[i], word_of(v, i));
      end
   endtask

   vec_t tbl[8];
   vec_t v1;

   initial begin
      tbl[0] = '{cnt:8'h02, nw:2, w0:32'h10000000, w1:32'h40003C0D, w2:32'h0, inc:1'b0,
                 sum:8'h61, gap:0, pulse_at:-1, exp_done:1'b1, exp_err:1'b0, exp_wl:6'd2};
      tbl[1] = '{cnt:8'h02, nw:2, w0:32'h10000000, w1:32'h40003C0D, w2:32'h0, inc:1'b0,
                 sum:8'h62, gap:0, pulse_at:-1, exp_done:1'b0, exp_err:1'b1, exp_wl:6'd2};
      tbl[2] = '{cnt:8'h00, nw:0, w0:32'h0, w1:32'h0, w2:32'h0, inc:1'b0,
                 sum:8'h00, gap:0, pulse_at:-1, exp_done:1'b0, exp_err:1'b1, exp_wl:6'd0};
      tbl[3] = '{cnt:8'h21, nw:0, w0:32'h0, w1:32'h0, w2:32'h0, inc:1'b0,
                 sum:8'h00, gap:0, pulse_at:-1, exp_done:1'b0, exp_err:1'b1, exp_wl:6'd0};
      tbl[4] = '{cnt:8'h03, nw:3, w0:32'hDEADBEEF, w1:32'h00000000, w2:32'hFFFFFFFF, inc:1'b0,
                 sum:8'h22, gap:3, pulse_at:-1, exp_done:1'b1, exp_err:1'b0, exp_wl:6'd3};
      tbl[5] = '{cnt:8'h01, nw:1, w0:32'hCAFEBABE, w1:32'h0, w2:32'h0, inc:1'b0,
                 sum:8'h30, gap:1, pulse_at:-1, exp_done:1'b1, exp_err:1'b0, exp_wl:6'd1};
      tbl[6] = '{cnt:8'h20, nw:32, w0:32'h0, w1:32'h0, w2:32'h0, inc:1'b1,
                 sum:8'h20, gap:0, pulse_at:10, exp_done:1'b1, exp_err:1'b0, exp_wl:6'd32};
      tbl[7] = '{cnt:8'hFF, nw:0, w0:32'h0, w1:32'h0, w2:32'h0, inc:1'b0,
                 sum:8'h00, gap:0, pulse_at:-1, exp_done:1'b0, exp_err:1'b1, exp_wl:6'd0};
      v1     = '{cnt:8'h01, nw:1, w0:32'h12345678, w1:32'h0, w2:32'h0, inc:1'b0,
                 sum:8'h08, gap:0, pulse_at:-1, exp_done:1'b1, exp_err:1'b0, exp_wl:6'd1};

      rst        = 1'b1;
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      #12;
      check("reset_flags", {27'd0, o_in_ready, o_mem_we, o_busy, o_done, o_error}, 32'd0);
      check("reset_addr", 32'(o_mem_addr), 32'd0);
      check("reset_wdata", o_mem_wdata, 32'd0);
      check("reset_words", 32'(o_words_loaded), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Bytes offered while idle must not be taken.
      in_valid = 1'b1;
      in_data  = 8'h05;
      repeat (3) @(negedge clk);
      check("idle_no_ready", 32'(o_in_ready), 32'd0);
      check("idle_no_busy", 32'(o_busy), 32'd0);
      in_valid = 1'b0;

      for (int k = 0; k < 8; k++) run_frame(tbl[k], $sformatf("vec%0d", k));

      // Reset after the count byte and two data bytes.
      wr_addr.delete();
      wr_data.delete();
      @(negedge clk);
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      #2 rst = 1'b1;
      #1;
      check("midrst_flags", {27'd0, o_in_ready, o_mem_we, o_busy, o_done, o_error}, 32'd0);
      check("midrst_addr", 32'(o_mem_addr), 32'd0);
      check("midrst_wdata", o_mem_wdata, 32'd0);
      check("midrst_words", 32'(o_words_loaded), 32'd0);
      check("midrst_no_write", 32'(wr_addr.size()), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_frame(v1, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Loads a program into the 32-word instruction memory before the CPU runs, acting as the memory's write side. It accepts a framed byte stream over a valid/ready handshake, packs bytes MSB-first into 32-bit instruction words, and writes them into consecutive addresses from 0. It also verifies a trailing XOR checksum and holds the core (`busy`) until the load finishes.

## Interface
- `DEPTH`, 32: instruction memory depth in words.
- `ADDR_W`, 5: memory address width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load_start`  in  1  one-cycle pulse that arms a new load.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `mem_we`  out  1  one-cycle write strobe to instruction memory.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  32  write data.
- `busy`  out  1  high from `load_start` until DONE/ERROR; CPU held while high.
- `done`  out  1  load complete, checksum good; sticky until next `load_start` or reset.
- `error`  out  1  bad count or checksum; sticky until next `load_start` or reset.
- `words_loaded`  out  ADDR_W+1  count of words written this load.

## Operation
- Frame: count byte N (1..DEPTH), then 4·N data bytes, each word MSB first, then one checksum byte. The checksum is the XOR of all data bytes; the count byte is excluded.
- States: IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + `load_start`: go to COUNT. On entry, clear `done`, `error`, `words_loaded`, checksum, byte index, and address (address = 0).
- `load_start` in COUNT/DATA/WRITE/CHECK is ignored.
- COUNT: accept one byte.
  - N = 0 or N > DEPTH: go to ERROR.
  - Otherwise latch N and go to DATA.
- DATA: each accepted byte shifts into the word register (`word = {word[23:0], byte}`) and XORs into the checksum. After the 4th byte of a word, go to WRITE.
- WRITE: `mem_we` = 1 for exactly one cycle with the current address and the packed word. Then `words_loaded`++ and address++.
  - If `words_loaded` is now N, go to CHECK.
  - Otherwise go to DATA.
- CHECK: accept one byte.
  - Equal to the running XOR: go to DONE (`done` = 1).
  - Otherwise go to ERROR (`error` = 1).
- Bytes presented while in IDLE/DONE/ERROR are not accepted (`in_ready` = 0).
- Words at addresses ≥ N are never written.
- A checksum failure does not undo writes already made.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_we`, `busy`, `done`, `error` = 0; `mem_addr`, `mem_wdata`, `words_loaded` = 0.
- All outputs are registered.
- `in_ready` = 1 in COUNT, DATA, CHECK; 0 in every other state. This gives a one-cycle bubble (WRITE) after every 4th data byte.
- `mem_we` asserts in the cycle after the handshake of a word's 4th byte.
- `done`/`error` assert in the cycle after the checksum handshake; for a bad count, in the cycle after the count handshake.
- `busy` rises the cycle after `load_start` and falls in the same cycle `done` or `error` rises.
- `in_valid` gaps stall the FSM with no state change. There is no timeout.
- Reset mid-load: all outputs return to reset values immediately. Memory contents already written are retained.
- `mem_addr` never wraps: at N = DEPTH the last write is to DEPTH−1.

## Structure
- Shared package `loader_pkg`: state enum, `DEPTH`, `ADDR_W`, byte/word width constants.
- Sub-module `byte_packer`: 4-byte shift register, byte index counter, running XOR. It has clear and shift-enable inputs and outputs `word`, `word_full`, `xor_sum`.
- The top level holds the FSM, address counter, and output registers.

## Test plan
- Nominal, N=2: bytes 02, 10 00 00 00, 40 00 3C 0D, checksum 61 → `mem_we` at addr 0 with 0x10000000, then at addr 1 with 0x40003C0D; `done`=1, `words_loaded`=2, `busy`=0.
- Bad checksum: same frame with checksum 62 → both writes occur; `error`=1, `done`=0.
- Bad count 00, then a new frame with count 21 (33) → `error`=1 after the count byte; no `mem_we`.
- Backpressure and gaps: random `in_valid` deassertion, N=3 → `in_ready`=0 exactly in each WRITE cycle; data 0xDEADBEEF, 0x00000000, 0xFFFFFFFF written to addresses 0–2 in order.
- Full depth: N=32 with an incrementing pattern, plus a `load_start` pulse mid-frame → the pulse is ignored; the last write goes to addr 31; `words_loaded`=32; `done`=1.
- `rst` asserted after the count byte and 2 data bytes → all outputs 0 asynchronously; a fresh N=1 frame then loads addr 0 and sets `done`.
